// File: rtl/prio_encoder_queue.sv
// Registered N-line priority encoder with sticky pending bits,
// per-line masking and a single-entry valid/ready output slot.
module prio_encoder_queue #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter bit MSB_PRIO = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     mask_i,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending_o,
  output logic             any_o,
  output logic             overflow_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  slot_e            state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     sel_vec, clear_vec;
  logic [IDX_W-1:0] idx_q, idx_d, sel_idx;
  logic             ovf_q, ovf_d;
  logic             sel_hit, load;

  assign sel_vec = pending_q & ~mask_i;
  assign sel_hit = |sel_vec;
  assign load    = (state_q == EMPTY) || out_ready;

  // Later iterations overwrite earlier ones, so the loop
  // direction sets which end of the vector wins.
  always_comb begin
    sel_idx = '0;
    if (MSB_PRIO) begin
      for (int i = 0; i < N; i++)
        if (sel_vec[i]) sel_idx = IDX_W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (sel_vec[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    clear_vec = '0;
    if (load) begin
      if (sel_hit) begin
        state_d            = FULL;
        idx_d              = sel_idx;
        clear_vec[sel_idx] = 1'b1;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // A new request beats a same-edge clear on its line.
  assign pending_d = (pending_q & ~clear_vec) | req_i;
  assign ovf_d     = |(req_i & pending_q & ~clear_vec);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      idx_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (N >= 2 && IDX_W == $clog2(N))
      else $error("prio_encoder_queue: bad N/IDX_W");
  end

  assign out_idx    = idx_q;
  assign out_valid  = (state_q == FULL);
  assign pending_o  = pending_q;
  assign any_o      = sel_hit;
  assign overflow_o = ovf_q;

endmodule
